// File: rtl/clk_div_pkg.sv
// clk_div_multi shared types and constants
// Mode encoding, default divisors and channel-select width helper
package clk_div_pkg;

    typedef enum logic {
        DIV_PULSE  = 1'b0,
        DIV_SQUARE = 1'b1
    } div_mode_e;

    // Divisors for a 100 MHz base clock
    localparam int unsigned DIV_40K = 2499;
    localparam int unsigned DIV_1M  = 99;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// clk_div_multi control/status bundle
// master drives configuration, slave is the divider
interface clk_div_multi_if
    import clk_div_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int CNT_W = 16
) ();

    localparam int CH_W = ch_w(N_CH);

    logic [N_CH-1:0]  en;
    logic [N_CH-1:0]  mode;
    logic             div_wr;
    logic [CH_W-1:0]  div_ch;
    logic [CNT_W-1:0] div_val;
    logic             sync;
    logic [N_CH-1:0]  tick;
    logic [N_CH-1:0]  clk_out;
    logic [N_CH-1:0]  upd_pend;

    modport master (
        output en, mode, div_wr, div_ch, div_val, sync,
        input  tick, clk_out, upd_pend
    );

    modport slave (
        input  en, mode, div_wr, div_ch, div_val, sync,
        output tick, clk_out, upd_pend
    );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow divisor, tick and square out
// Divisor writes while running are deferred to the next terminal count
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int          CNT_W   = 16,
    parameter int unsigned DIV_RST = DIV_40K
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  div_mode_e        i_mode,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_val,
    input  logic             i_sync,
    output logic             o_tick,
    output logic             o_clk_out,
    output logic             o_upd_pend
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_shadow;
    logic             r_upd_pend;
    logic             r_tick;
    logic             r_clk_out;
    logic             w_term;

    assign w_term = (r_cnt == r_div_act);

    // Counter, divisor shadowing and output flops in priority order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_div_act  <= CNT_W'(DIV_RST);
            r_shadow   <= CNT_W'(DIV_RST);
            r_upd_pend <= 1'b0;
            r_tick     <= 1'b0;
            r_clk_out  <= 1'b0;
        end else if (i_sync) begin
            r_cnt     <= '0;
            r_tick    <= 1'b0;
            r_clk_out <= 1'b0;
            if (r_upd_pend) begin
                r_div_act <= r_shadow;
            end
            if (i_wr) begin
                r_shadow   <= i_val;
                r_upd_pend <= 1'b1;
            end else begin
                r_upd_pend <= 1'b0;
            end
        end else if (!i_en) begin
            // Idle channel: nothing to glitch, so divisor lands directly
            r_cnt      <= '0;
            r_tick     <= 1'b0;
            r_clk_out  <= 1'b0;
            r_upd_pend <= 1'b0;
            if (i_wr) begin
                r_div_act <= i_val;
                r_shadow  <= i_val;
            end else if (r_upd_pend) begin
                r_div_act <= r_shadow;
            end
        end else if (w_term) begin
            r_cnt     <= '0;
            r_tick    <= (i_mode == DIV_PULSE);
            r_clk_out <= (i_mode == DIV_SQUARE) ? ~r_clk_out : 1'b0;
            if (r_upd_pend) begin
                r_div_act <= r_shadow;
            end
            // A write coinciding with terminal waits for the next one
            if (i_wr) begin
                r_shadow   <= i_val;
                r_upd_pend <= 1'b1;
            end else begin
                r_upd_pend <= 1'b0;
            end
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
            if (i_mode == DIV_PULSE) begin
                r_clk_out <= 1'b0;
            end
            if (i_wr) begin
                r_shadow   <= i_val;
                r_upd_pend <= 1'b1;
            end
        end
    end

    assign o_tick     = r_tick;
    assign o_clk_out  = r_clk_out;
    assign o_upd_pend = r_upd_pend;

endmodule

// File: rtl/clk_div_multi.sv
// N-channel programmable tick / square-enable divider
// Decodes divisor writes into per-channel strobes
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int          N_CH    = 2,
    parameter int          CNT_W   = 16,
    parameter int unsigned DIV_RST = DIV_40K
) (
    input  logic            clk,
    input  logic            rst_n,
    clk_div_multi_if.slave  bus
);

    localparam int CH_W = ch_w(N_CH);

    logic [N_CH-1:0] w_wr;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        // Out-of-range channel numbers match no strobe
        assign w_wr[i] = bus.div_wr && (bus.div_ch == CH_W'(i));

        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_RST)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_en       (bus.en[i]),
            .i_mode     (div_mode_e'(bus.mode[i])),
            .i_wr       (w_wr[i]),
            .i_val      (bus.div_val),
            .i_sync     (bus.sync),
            .o_tick     (bus.tick[i]),
            .o_clk_out  (bus.clk_out[i]),
            .o_upd_pend (bus.upd_pend[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi, three channels so an
// out-of-range channel number is representable
module tb_clk_div_multi;

    localparam int N  = 3;
    localparam int CW = 16;

    logic clk;
    logic rst_n;

    clk_div_multi_if #(.N_CH(N), .CNT_W(CW)) bus ();

    clk_div_multi #(
        .N_CH    (N),
        .CNT_W   (CW),
        .DIV_RST (2499)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_pass;

    logic [N-1:0] th [1:64];
    logic [N-1:0] co [1:64];
    logic [N-1:0] up [1:64];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 1; k <= n; k++) begin
            step();
            th[k] = bus.tick;
            co[k] = bus.clk_out;
            up[k] = bus.upd_pend;
        end
    endtask

    function automatic logic [63:0] pick(input int which, input int ch,
                                         input int n);
        logic [63:0] v;
        v = '0;
        for (int k = 1; k <= n; k++) begin
            case (which)
                0:       v[k-1] = th[k][ch];
                1:       v[k-1] = co[k][ch];
                default: v[k-1] = up[k][ch];
            endcase
        end
        return v;
    endfunction

    task automatic wr_div(input int ch, input int val);
        bus.div_wr  = 1'b1;
        bus.div_ch  = 2'(ch);
        bus.div_val = 16'(val);
        step();
        bus.div_wr  = 1'b0;
    endtask

    task automatic count_ticks(input int n, output int first,
                               output int last, output int cnt);
        first = 0;
        last  = 0;
        cnt   = 0;
        for (int k = 1; k <= n; k++) begin
            step();
            if (bus.tick[0]) begin
                if (first == 0) first = k;
                last = k;
                cnt++;
            end
        end
    endtask

    logic [63:0] e;
    int f, l, c;

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n       = 1'b0;
        bus.en      = '0;
        bus.mode    = '0;
        bus.div_wr  = 1'b0;
        bus.div_ch  = '0;
        bus.div_val = '0;
        bus.sync    = 1'b0;
        repeat (3) step();
        check("rst_tick", 64'(bus.tick), 64'h0);
        check("rst_clk_out", 64'(bus.clk_out), 64'h0);
        check("rst_upd_pend", 64'(bus.upd_pend), 64'h0);
        rst_n = 1'b1;

        // T1: default divisor, ch0 PULSE, ch1 SQUARE
        bus.en   = 3'b011;
        bus.mode = 3'b010;
        count_ticks(2600, f, l, c);
        check("t1_first_tick", 64'(f), 64'd2500);
        check("t1_tick_cnt", 64'(c), 64'd1);
        check("t1_ch1_high", 64'(bus.clk_out[1]), 64'h1);
        wr_div(0, 7);
        check("t1_pend", 64'(bus.upd_pend), 64'h1);
        rst_n = 1'b0;
        #1;
        check("t1_async_tick", 64'(bus.tick), 64'h0);
        check("t1_async_clk", 64'(bus.clk_out), 64'h0);
        check("t1_async_pend", 64'(bus.upd_pend), 64'h0);
        rst_n = 1'b1;
        count_ticks(5000, f, l, c);
        check("t1_rel_first", 64'(f), 64'd2500);
        check("t1_rel_last", 64'(l), 64'd5000);
        check("t1_rel_cnt", 64'(c), 64'd2);

        // T2: D=3 on ch0 PULSE and ch1 SQUARE
        bus.en = '0;
        step();
        wr_div(0, 3);
        wr_div(1, 3);
        check("t2_no_pend", 64'(bus.upd_pend), 64'h0);
        bus.en   = 3'b011;
        bus.mode = 3'b010;
        run(16);
        e = '0;
        for (int k = 1; k <= 16; k++) e[k-1] = (k % 4 == 0);
        check("t2_tick0", pick(0, 0, 16), e);
        e = '0;
        for (int k = 1; k <= 16; k++) e[k-1] = ((k / 4) % 2 == 1);
        check("t2_clk1", pick(1, 1, 16), e);
        check("t2_tick1", pick(0, 1, 16), 64'h0);
        check("t2_clk0", pick(1, 0, 16), 64'h0);

        // T3: D=9 running, write D=4 when cnt=2
        bus.en = '0;
        step();
        wr_div(0, 9);
        bus.mode = 3'b000;
        bus.en   = 3'b001;
        run(2);
        wr_div(0, 4);
        check("t3_pend_set", 64'(bus.upd_pend[0]), 64'h1);
        run(17);
        e = '0;
        for (int j = 1; j <= 17; j++)
            e[j-1] = (j + 3 == 10) || (j + 3 == 15) || (j + 3 == 20);
        check("t3_tick", pick(0, 0, 17), e);
        e = '0;
        for (int j = 1; j <= 17; j++) e[j-1] = (j + 3 < 10);
        check("t3_pend", pick(2, 0, 17), e);

        // T4: D=0, then a write to a non-existent channel
        bus.en = '0;
        step();
        wr_div(0, 0);
        wr_div(1, 0);
        bus.mode = 3'b010;
        bus.en   = 3'b011;
        run(8);
        check("t4_tick0_held", pick(0, 0, 8), 64'hFF);
        e = '0;
        for (int k = 1; k <= 8; k++) e[k-1] = k[0];
        check("t4_clk1_div2", pick(1, 1, 8), e);
        check("t4_tick1", pick(0, 1, 8), 64'h0);
        wr_div(3, 5);
        check("t4_bad_ch_pend", 64'(bus.upd_pend), 64'h0);
        run(6);
        check("t4_bad_ch_tick", pick(0, 0, 6), 64'h3F);
        bus.mode = 3'b000;
        step();
        check("t4_mode_clk", 64'(bus.clk_out), 64'h0);
        check("t4_mode_tick", 64'(bus.tick), 64'h3);

        // T5: sync at arbitrary phase, then on a terminal count
        bus.en = '0;
        step();
        wr_div(0, 4);
        wr_div(1, 9);
        bus.mode = 3'b000;
        bus.en   = 3'b011;
        run(7);
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        run(12);
        check("t5_tick0", pick(0, 0, 12), 64'h210);
        check("t5_tick1", pick(0, 1, 12), 64'h200);
        run(2);
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        check("t5_sync_prio", 64'(bus.tick[0]), 64'h0);
        run(5);
        check("t5_after_prio", pick(0, 0, 5), 64'h10);

        // T6: write with en low lands immediately
        run(2);
        bus.en = 3'b010;
        step();
        wr_div(0, 6);
        check("t6_no_pend", 64'(bus.upd_pend[0]), 64'h0);
        bus.en = 3'b011;
        run(14);
        check("t6_tick0", pick(0, 0, 14), 64'h2040);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
